// File: rtl/uart_echo_demo.sv
// UART echo demo: receives 8N1 bytes on uart_rx and retransmits each valid byte on uart_tx.
// Holds one byte between the receiver and the baud-paced serializer.

module baud_pulse_gen #(
    parameter int DIV = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic baud_pulse
);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    logic [15:0] cnt_r;

    // Bit-period divider, parked at zero while disabled so each frame starts aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (!en) begin
            cnt_r <= 16'd0;
        end else if (cnt_r == DIV_M1) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign baud_pulse = en && (cnt_r == DIV_M1);
endmodule

module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       baud_pulse,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] STOP  = 2'b10;
    localparam logic [1:0] DATA  = 2'b11;

    logic [1:0] state_r;
    logic [2:0] data_baud_cnt_r;
    logic [7:0] data_r;
    logic       busy_r;
    logic       tx_r;
    logic [2:0] next_cnt_s;
    logic [2:0] bit_idx_s;

    // The line index of the next data bit follows the down-counter, LSB first
    assign next_cnt_s = data_baud_cnt_r - 3'd1;
    assign bit_idx_s  = 3'd7 - next_cnt_s;

    // Frame sequencer: start, eight data bits, stop, each one baud pulse long
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            data_baud_cnt_r <= 3'd0;
            data_r          <= 8'd0;
            busy_r          <= 1'b0;
            tx_r            <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        data_r  <= data;
                        busy_r  <= 1'b1;
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (baud_pulse) begin
                        tx_r            <= data_r[0];
                        data_baud_cnt_r <= 3'd7;
                        state_r         <= DATA;
                    end
                end
                DATA: begin
                    if (baud_pulse) begin
                        if (data_baud_cnt_r == 3'd0) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            data_baud_cnt_r <= next_cnt_s;
                            tx_r            <= data_r[bit_idx_s];
                        end
                    end
                end
                STOP: begin
                    if (baud_pulse) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign tx   = tx_r;
endmodule

module uart_rx_core #(
    parameter int DIV = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data
);
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'((DIV / 2) - 1);

    localparam logic [1:0] RX_IDLE  = 2'b00;
    localparam logic [1:0] RX_START = 2'b01;
    localparam logic [1:0] RX_DATA  = 2'b10;
    localparam logic [1:0] RX_STOP  = 2'b11;

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic [1:0]  state_r;
    logic [15:0] cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        rx_valid_r;
    logic [7:0]  rx_data_r;

    // Two-flop synchronizer plus one history stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Mid-bit sampler; a start bit that is high again at half a bit is a glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RX_IDLE;
            cnt_r      <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'd0;
        end else begin
            rx_valid_r <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    cnt_r     <= 16'd0;
                    bit_cnt_r <= 3'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r   <= 16'd0;
                        state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == DIV_M1) begin
                        cnt_r     <= 16'd0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == DIV_M1) begin
                        cnt_r   <= 16'd0;
                        state_r <= RX_IDLE;
                        if (rx_sync_r) begin
                            rx_valid_r <= 1'b1;
                            rx_data_r  <= shift_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                    cnt_r   <= 16'd0;
                end
            endcase
        end
    end

    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
endmodule

module uart_echo_demo #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output logic uart_tx
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;

    logic       rx_valid_s;
    logic [7:0] rx_data_s;
    logic       hold_full_r;
    logic [7:0] hold_data_r;
    logic       req_r;
    logic [7:0] req_data_r;
    logic       clr_s;
    logic       tx_busy_s;
    logic       baud_pulse_s;
    logic       tx_s;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .rx_valid (rx_valid_s),
        .rx_data  (rx_data_s)
    );

    // req_r blocks a second launch in the cycle before busy rises
    assign clr_s = hold_full_r && !tx_busy_s && !req_r;

    // One-byte holding register; the launched byte is copied so a refill cannot corrupt it
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_r <= 1'b0;
            hold_data_r <= 8'd0;
            req_r       <= 1'b0;
            req_data_r  <= 8'd0;
        end else begin
            req_r <= clr_s;
            if (clr_s) begin
                req_data_r <= hold_data_r;
            end
            if (rx_valid_s && (!hold_full_r || clr_s)) begin
                hold_data_r <= rx_data_s;
                hold_full_r <= 1'b1;
            end else if (clr_s) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    baud_pulse_gen #(.DIV(DIV)) u_bpg (
        .clk        (clk),
        .rst        (rst),
        .en         (tx_busy_s),
        .baud_pulse (baud_pulse_s)
    );

    uart_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .req        (req_r),
        .baud_pulse (baud_pulse_s),
        .data       (req_data_r),
        .busy       (tx_busy_s),
        .tx         (tx_s)
    );

    assign uart_tx = tx_s;
endmodule

// File: tb/tb_uart_echo_demo.sv
// Bench for uart_echo_demo: random 8N1 traffic against a queue-based echo model and a line decoder.
module tb_uart_echo_demo;
    localparam int DIV = 25_000_000 / 115200;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic uart_tx;
    logic bpg_en;
    logic bpg_pulse;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         okf_q[$];
    int         got_t[$];
    int         sent_t[$];

    uart_echo_demo #(.CLK_FREQ(25_000_000), .BAUD_RATE(115200)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    baud_pulse_gen #(.DIV(DIV)) u_bpg (
        .clk        (clk),
        .rst        (rst),
        .en         (bpg_en),
        .baud_pulse (bpg_pulse)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: every bit must hold its level from one clock in to two clocks before its end
    initial begin : tx_monitor
        logic [7:0] b;
        logic       v;
        bit         ok;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                got_t.push_back(cyc);
                ok = 1'b1;
                b  = 8'h00;
                repeat (DIV - 2) @(negedge clk);
                if (uart_tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 9; i++) begin
                    repeat (3) @(negedge clk);
                    v = uart_tx;
                    repeat (DIV - 3) @(negedge clk);
                    if (uart_tx !== v) ok = 1'b0;
                    if (i < 8) b[i] = v;
                    else if (v !== 1'b1) ok = 1'b0;
                end
                got_q.push_back(b);
                okf_q.push_back(ok);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        sent_t.push_back(cyc);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_arrived"}, 32'(got_q.size()), 32'(n));
    endtask

    task automatic drain(input string tag);
        logic [7:0] g;
        bit         ok;
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g  = got_q.pop_front();
            ok = okf_q.pop_front();
            check_eq({tag, "_shape"}, 32'(ok), 32'd1);
            check_eq({tag, "_byte"}, 32'(g), 32'(exp_q.pop_front()));
        end
        got_q.delete(); okf_q.delete(); exp_q.delete(); got_t.delete(); sent_t.delete();
    endtask

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         d;
        int         c0;
        int         pulses[$];
        logic [7:0] r;

        rst = 1'b1; uart_rx = 1'b1; bpg_en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_tx_idle", 32'(uart_tx), 32'd1);
        check_eq("reset_busy", 32'(dut.tx_busy_s), 32'd0);
        check_eq("reset_cnt", 32'(dut.u_bpg.cnt_r), 32'd0);
        mon_en = 1'b1;

        // Single byte, including echo latency measured from the input start edge
        exp_q.push_back(8'hAA);
        send_byte(8'hAA, 1'b1);
        wait_frames("single", 1, 12 * DIV);
        if (got_t.size() > 0 && sent_t.size() > 0) begin
            d = got_t[0] - sent_t[0];
            check_eq("echo_latency", 32'(d >= 9 * DIV + DIV / 2 && d <= 9 * DIV + DIV / 2 + 12), 32'd1);
        end
        drain("single");

        // Continuous back-to-back stream: must be echoed in order without loss
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) begin
            r = exp_q[i];
            send_byte(r, 1'b1);
        end
        wait_frames("stream", 6, 14 * DIV);
        drain("stream");
        repeat (2 * DIV) @(negedge clk);
        check_eq("stream_idle_high", 32'(uart_tx), 32'd1);

        // Framing error discards the byte; the receiver still accepts the next one
        send_byte(8'h55, 1'b0);
        repeat (12 * DIV) @(negedge clk);
        check_eq("framing_no_echo", 32'(got_q.size()), 32'd0);
        check_eq("framing_tx_high", 32'(uart_tx), 32'd1);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        wait_frames("after_framing", 1, 12 * DIV);
        drain("after_framing");

        // Short low glitch is rejected at the half-bit check
        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        check_eq("glitch_no_echo", 32'(got_q.size()), 32'd0);
        check_eq("glitch_tx_high", 32'(uart_tx), 32'd1);

        // Reset while the echo is in its data bits
        send_byte(8'h5A, 1'b1);
        d = 0;
        while (got_t.size() == 0 && d < 4 * DIV) begin
            @(negedge clk);
            d++;
        end
        check_eq("reset_echo_started", 32'(got_t.size()), 32'd1);
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midtx_rst_tx", 32'(uart_tx), 32'd1);
        check_eq("midtx_rst_busy", 32'(dut.tx_busy_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * DIV) @(negedge clk);
        got_q.delete(); okf_q.delete(); got_t.delete(); sent_t.delete();
        check_eq("post_reset_tx_high", 32'(uart_tx), 32'd1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_frames("post_reset", 1, 12 * DIV);
        drain("post_reset");

        // Baud generator run standalone with en held high, then dropped
        @(negedge clk);
        bpg_en = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3 * DIV; k++) begin
            @(negedge clk);
            if (bpg_pulse === 1'b1) pulses.push_back(cyc - c0);
        end
        check_eq("bpg_pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check_eq("bpg_first", 32'(pulses[0]), 32'(DIV - 1));
            check_eq("bpg_period_1", 32'(pulses[1] - pulses[0]), 32'(DIV));
            check_eq("bpg_period_2", 32'(pulses[2] - pulses[1]), 32'(DIV));
        end
        repeat (50) @(negedge clk);
        bpg_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("bpg_cnt_cleared", 32'(u_bpg.cnt_r), 32'd0);
        check_eq("bpg_no_pulse_disabled", 32'(bpg_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_echo_demo.md
# uart_echo_demo

UART echo block for the 30K evaluation board demo: it receives 8N1 serial bytes on `uart_rx` and retransmits each valid byte unchanged on `uart_tx`. The block is the top of the UART demo. It contains three parts: an input receiver, a one-byte holding register, and a transmit path. The transmit path is built from a baud pulse generator (`baud_pulse_gen`) and a byte serializer (`uart_tx`).

## Interface
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: serial bit rate. DIV = CLK_FREQ / BAUD_RATE, integer-truncated. The default is 217 clocks per bit.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `uart_rx`  input  1  serial input, asynchronous, idle high.
- `uart_tx`  output  1  serial output, idle high.

## Operation
- **Baud pulse generator**
  - 16-bit counter `cnt`, enabled by `en`.
  - While `en` = 0: `cnt` = 0 and no pulse.
  - While `en` = 1: `cnt` increments each clock. When `cnt` = DIV-1, it emits a one-cycle `baud_pulse` and wraps to 0.
- **Transmitter states**: IDLE = 2'b00, START = 2'b01, STOP = 2'b10, DATA = 2'b11. It has a 3-bit `data_baud_cnt`. Handshake signals are `req` (input), `busy` and `tx` (outputs).
  - IDLE, with `req` = 1: latch the byte, set `busy` = 1 and `tx` = 0, and go to START.
  - START, on a pulse: `tx` = bit 0, go to DATA with `data_baud_cnt` = 7.
  - DATA, on each pulse: if `data_baud_cnt` = 0, set `tx` = 1 and go to STOP. Otherwise decrement `data_baud_cnt` and output the next bit, LSB first. The bit index on the line is 7 - `data_baud_cnt`.
  - STOP, on a pulse: set `busy` = 0 and return to IDLE.
- The baud generator `en` equals the transmitter's `busy`, so `cnt` restarts at 0 for each frame.
- **Receiver**
  - Two-flop synchronizer on `uart_rx`. A falling edge seen in idle starts a frame.
  - The start bit is checked at DIV/2 clocks. If the line is high, the receiver returns to idle, which rejects glitches.
  - Each data bit is then sampled every DIV clocks, at mid-bit, LSB first. The stop bit is sampled the same way.
  - If the stop bit is 1, the receiver pulses `rx_valid` for one clock with the byte. If the stop bit is 0 (framing error), the byte is discarded.
  - After the stop sample, the receiver is immediately ready for the next start edge.
- **Echo control**
  - On `rx_valid`, the byte goes into the one-byte holding register. If the register is already full, the new byte is dropped.
  - When the holding register is full and the transmitter is idle, the control asserts `req` for one cycle and clears the register.
  - If `rx_valid` and the register-clear happen on the same cycle, the new byte is stored.

## Timing
- **Reset values**:
  - `uart_tx` = 1, `busy` = 0, state IDLE, `cnt` = 0, `data_baud_cnt` = 0.
  - Holding register empty; receiver idle.
- A reset asserted mid-frame aborts both directions. `uart_tx` is high on the cycle after reset is sampled.
- **TX frame length**: start, 8 data bits and stop, each exactly DIV clocks, so 10·DIV clocks in total (2170 at defaults).
- The start bit drives `uart_tx` low on the clock after `req` is accepted.
- `busy` stays high from the cycle after `req` until the STOP pulse. The next `req` can be accepted on the cycle `busy` falls.
- **Echo latency**: `rx_valid` occurs at mid-stop-bit, about 9.5·DIV clocks after the input start edge. The output start bit follows `rx_valid` within 3 clocks when the transmitter is idle.
- Because the echo starts at mid-stop-bit, a continuous back-to-back input stream at the same baud rate is echoed without loss.

## Test plan
- **Single byte**: reset, then drive 8N1 0xAA at 115200 on `uart_rx`. Required: `uart_tx` carries start 0, then bits 0,1,0,1,0,1,0,1, then stop 1. Sampling at `cnt` = 2 in DATA gives data[0..7] = 0,1,0,1,0,1,0,1. Each bit is 217 clocks.
- **Two bytes back-to-back**: send 0xAA, then a random byte such as 0x24. Required: both are echoed in order with correct values, and `uart_tx` is idle high afterwards.
- **Framing error**: send 0x55 with the stop bit forced to 0. Required: no output frame; `uart_tx` stays 1.
- **Glitch**: drive `uart_rx` low for 50 clocks. Required: no byte received; `uart_tx` stays 1.
- **Reset mid-transmission**: assert `rst` during the DATA state of an echo. Required: `uart_tx` = 1 on the next cycle, `busy` = 0, and a following 0x3C is echoed correctly.
- **Baud generator**: with `en` held at 1, `baud_pulse` occurs every 217 clocks. Dropping `en` clears `cnt` to 0 within one clock.
